// File: rtl/element_delay_tracker_pkg.sv
// Shared definitions for the element delay tracker and its term producer:
// FSM state encoding and the default fixed-point widths of the K_n terms.
package element_delay_tracker_pkg;

    localparam int unsigned DEF_DW_INTEGER   = 18;
    localparam int unsigned DEF_DW_FRACTION  = 6;
    localparam int unsigned DEF_DW_DELAY     = 12;
    localparam int unsigned DEF_NUM_ELEMENTS = 64;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TERM = 2'd1,
        ADJUST    = 2'd2,
        PRESENT   = 2'd3
    } state_t;

endpackage

// File: rtl/element_delay_tracker_delay_side_stepper.sv
// delay_side_stepper: one error-accumulator / integer-delay pair.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   i_load, i_d_init load d with i_d_init and clear e
//   i_add, i_term    accumulate a signed term into e
//   i_step           apply at most one +/-1 correction step to d
//   o_d, o_e         current delay and error accumulator
//   o_settled_c      combinational: no step would be taken this cycle
module delay_side_stepper #(
    parameter int unsigned DW_DELAY    = 12,
    parameter int unsigned DW_FRACTION = 6,
    parameter int unsigned EW          = 26
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_load,
    input  logic [DW_DELAY-1:0]        i_d_init,
    input  logic                       i_add,
    input  logic signed [EW-1:0]       i_term,
    input  logic                       i_step,
    output logic [DW_DELAY-1:0]        o_d,
    output logic signed [EW-1:0]       o_e,
    output logic                       o_settled_c
);

    logic signed [EW-1:0] w_thr_up;
    logic signed [EW-1:0] w_thr_dn;
    logic                 w_up;
    logic                 w_dn;

    // Thresholds (2d+1) and (2d-1) in the same fixed-point scale as e.
    // The (2d-1) value is only consumed when d > 0, so its d=0 wrap is harmless.
    assign w_thr_up = $signed(EW'({o_d, 1'b1}) << DW_FRACTION);
    assign w_thr_dn = $signed(EW'({o_d, 1'b0} - (DW_DELAY+1)'(1)) << DW_FRACTION);

    // Saturated d (all-ones up, zero down) blocks the step and counts as settled.
    assign w_up        = (o_e >= w_thr_up) && (o_d != {DW_DELAY{1'b1}});
    assign w_dn        = o_e[EW-1] && (o_d != '0);
    assign o_settled_c = !w_up && !w_dn;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_d <= '0;
            o_e <= '0;
        end else if (i_load) begin
            o_d <= i_d_init;
            o_e <= '0;
        end else if (i_add) begin
            o_e <= o_e + i_term;
        end else if (i_step) begin
            if (w_up) begin
                o_e <= o_e - w_thr_up;
                o_d <= o_d + DW_DELAY'(1);
            end else if (w_dn) begin
                o_e <= o_e + w_thr_dn;
                o_d <= o_d - DW_DELAY'(1);
            end
        end
    end

endmodule

// File: rtl/element_delay_tracker.sv
// element_delay_tracker: tracks integer element delays on both sides of an
// array centre from a stream of fixed-point K_n(+)/K_n(-) term pairs.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start, d_init               begin a run with initial centre delay
//   term_pos, term_neg          signed K_n terms from the producer
//   term_ready, last_element    producer valid level / final-pair flag
//   term_ack                    one-cycle acknowledge of a consumed pair
//   delay_pos, delay_neg        integer delays presented downstream
//   element_index               index of the presented term pair
//   delay_valid, delay_ack      downstream handshake
//   done                        one-cycle end-of-run pulse
module element_delay_tracker
    import element_delay_tracker_pkg::*;
#(
    parameter int unsigned DW_INTEGER   = DEF_DW_INTEGER,
    parameter int unsigned DW_FRACTION  = DEF_DW_FRACTION,
    parameter int unsigned DW_DELAY     = DEF_DW_DELAY,
    parameter int unsigned NUM_ELEMENTS = DEF_NUM_ELEMENTS
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [DW_DELAY-1:0]                   d_init,
    input  logic signed [DW_INTEGER+DW_FRACTION-1:0] term_pos,
    input  logic signed [DW_INTEGER+DW_FRACTION-1:0] term_neg,
    input  logic                                  term_ready,
    input  logic                                  last_element,
    output logic                                  term_ack,
    output logic [DW_DELAY-1:0]                   delay_pos,
    output logic [DW_DELAY-1:0]                   delay_neg,
    output logic [$clog2(NUM_ELEMENTS)-1:0]       element_index,
    output logic                                  delay_valid,
    input  logic                                  delay_ack,
    output logic                                  done
);

    localparam int unsigned TW = DW_INTEGER + DW_FRACTION;
    localparam int unsigned EW = TW + 2;
    localparam int unsigned IW = $clog2(NUM_ELEMENTS);

    state_t               r_state;
    logic                 r_last;

    logic                 w_load;
    logic                 w_add;
    logic                 w_step;
    logic [DW_DELAY-1:0]  w_d_pos;
    logic [DW_DELAY-1:0]  w_d_neg;
    logic signed [EW-1:0] w_e_pos;
    logic signed [EW-1:0] w_e_neg;
    logic                 w_settled_pos;
    logic                 w_settled_neg;

    assign w_load = (r_state == IDLE) && start;
    assign w_add  = (r_state == WAIT_TERM) && term_ready;
    assign w_step = (r_state == ADJUST);

    delay_side_stepper #(
        .DW_DELAY   (DW_DELAY),
        .DW_FRACTION(DW_FRACTION),
        .EW         (EW)
    ) u_pos (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_d_init   (d_init),
        .i_add      (w_add),
        .i_term     (EW'(term_pos)),
        .i_step     (w_step),
        .o_d        (w_d_pos),
        .o_e        (w_e_pos),
        .o_settled_c(w_settled_pos)
    );

    delay_side_stepper #(
        .DW_DELAY   (DW_DELAY),
        .DW_FRACTION(DW_FRACTION),
        .EW         (EW)
    ) u_neg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_d_init   (d_init),
        .i_add      (w_add),
        .i_term     (EW'(term_neg)),
        .i_step     (w_step),
        .o_d        (w_d_neg),
        .o_e        (w_e_neg),
        .o_settled_c(w_settled_neg)
    );

    // Run control; all handshake outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_last        <= 1'b0;
            term_ack      <= 1'b0;
            delay_valid   <= 1'b0;
            done          <= 1'b0;
            delay_pos     <= '0;
            delay_neg     <= '0;
            element_index <= '0;
        end else begin
            term_ack <= 1'b0;
            done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        element_index <= '0;
                        r_state       <= WAIT_TERM;
                    end
                end
                WAIT_TERM: begin
                    if (term_ready) begin
                        r_last   <= last_element;
                        term_ack <= 1'b1;
                        r_state  <= ADJUST;
                    end
                end
                ADJUST: begin
                    if (w_settled_pos && w_settled_neg) begin
                        delay_pos   <= w_d_pos;
                        delay_neg   <= w_d_neg;
                        delay_valid <= 1'b1;
                        r_state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (delay_ack) begin
                        delay_valid <= 1'b0;
                        if (r_last) begin
                            done    <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            element_index <= element_index + IW'(1);
                            r_state       <= WAIT_TERM;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Accumulators are observed only inside the steppers.
    logic w_unused;
    assign w_unused = ^{w_e_pos, w_e_neg};

endmodule

// File: tb/tb_element_delay_tracker.sv
// Directed, table-driven bench for element_delay_tracker.
module tb_element_delay_tracker;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [11:0]        d_init;
    logic signed [23:0] term_pos;
    logic signed [23:0] term_neg;
    logic               term_ready;
    logic               last_element;
    logic               term_ack;
    logic [11:0]        delay_pos;
    logic [11:0]        delay_neg;
    logic [5:0]         element_index;
    logic               delay_valid;
    logic               delay_ack;
    logic               done;

    element_delay_tracker dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .d_init       (d_init),
        .term_pos     (term_pos),
        .term_neg     (term_neg),
        .term_ready   (term_ready),
        .last_element (last_element),
        .term_ack     (term_ack),
        .delay_pos    (delay_pos),
        .delay_neg    (delay_neg),
        .element_index(element_index),
        .delay_valid  (delay_valid),
        .delay_ack    (delay_ack),
        .done         (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Handshake monitors, sampled mid-cycle.
    int ack_cnt  = 0;
    int done_cnt = 0;
    int ack_long = 0;
    logic prev_ack = 1'b0;
    always @(negedge clk) begin
        if (term_ack) ack_cnt++;
        if (done) done_cnt++;
        if (term_ack && prev_ack) ack_long++;
        prev_ack = term_ack;
    end

    typedef struct {
        int d0;
        int tp;
        int tn;
        int exp_pos;
        int exp_neg;
        int exp_lat;
        int exp_epos;
        int exp_eneg;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Count edges from term capture until delay_valid; 99 on timeout.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!delay_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!delay_valid) lat = 99;
    endtask

    task automatic run_vector(input int i);
        int lat;
        int a0;
        start  = 1'b1;
        d_init = 12'(vecs[i].d0);
        tick();
        start        = 1'b0;
        term_pos     = 24'(vecs[i].tp);
        term_neg     = 24'(vecs[i].tn);
        term_ready   = 1'b1;
        last_element = 1'b1;
        a0 = ack_cnt;
        tick();
        chk($sformatf("v%0d term_ack", i), longint'(term_ack), 1);
        term_ready = 1'b0;
        wait_valid(lat);
        chk($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
        chk($sformatf("v%0d delay_pos", i), delay_pos, vecs[i].exp_pos);
        chk($sformatf("v%0d delay_neg", i), delay_neg, vecs[i].exp_neg);
        chk($sformatf("v%0d e_pos", i), longint'($signed(dut.u_pos.o_e)), vecs[i].exp_epos);
        chk($sformatf("v%0d e_neg", i), longint'($signed(dut.u_neg.o_e)), vecs[i].exp_eneg);
        chk($sformatf("v%0d index", i), element_index, 0);
        chk($sformatf("v%0d ack count", i), ack_cnt - a0, 1);
        delay_ack = 1'b1;
        tick();
        delay_ack = 1'b0;
        chk($sformatf("v%0d done", i), longint'(done), 1);
        chk($sformatf("v%0d valid drop", i), longint'(delay_valid), 0);
        tick();
        chk($sformatf("v%0d done pulse", i), longint'(done), 0);
    endtask

    initial begin
        int lat;
        int a0;
        int d0;
        bit stable;

        //          d0    tp      tn     pos   neg  lat  e_pos   e_neg
        vecs[0] = '{5,    0,      0,     5,    5,   2,   0,      0};
        vecs[1] = '{10,   1344,   0,     11,   10,  3,   0,      0};
        vecs[2] = '{10,   2816,   0,     12,   10,  4,   0,      0};
        vecs[3] = '{10,   0,      -1216, 10,   9,   3,   0,      0};
        vecs[4] = '{0,    -640,   0,     0,    0,   2,   -640,   0};
        vecs[5] = '{4095, 600000, 0,     4095, 4095,2,   600000, 0};
        vecs[6] = '{10,   1344,   -1216, 11,   9,   3,   0,      0};
        vecs[7] = '{10,   1400,   -100,  11,   9,   3,   56,     1116};
        vecs[8] = '{1,    0,      -5000, 1,    0,   3,   0,      -4936};

        rst = 1'b1; start = 1'b0; d_init = '0; term_pos = '0; term_neg = '0;
        term_ready = 1'b0; last_element = 1'b0; delay_ack = 1'b0;
        tick();
        tick();
        chk("reset valid", longint'(delay_valid), 0);
        chk("reset term_ack", longint'(term_ack), 0);
        chk("reset done", longint'(done), 0);
        chk("reset delay_pos", delay_pos, 0);
        chk("reset index", element_index, 0);
        rst = 1'b0;

        // Stray handshakes in IDLE must not produce activity.
        term_ready = 1'b1;
        delay_ack  = 1'b1;
        a0 = ack_cnt;
        tick();
        tick();
        term_ready = 1'b0;
        delay_ack  = 1'b0;
        chk("idle no ack", ack_cnt - a0, 0);
        chk("idle no valid", longint'(delay_valid), 0);

        for (int i = 0; i < 9; i++) run_vector(i);

        // 32 pairs, term_ready held high throughout, downstream ack 5 cycles late,
        // start held (and d_init changed) while the run is active.
        a0 = ack_cnt;
        d0 = done_cnt;
        start    = 1'b1;
        d_init   = 12'd7;
        term_pos = '0;
        term_neg = '0;
        tick();
        d_init     = 12'd99;
        term_ready = 1'b1;
        stable     = 1'b1;
        for (int k = 0; k < 32; k++) begin
            last_element = (k == 31);
            if (k == 31) start = 1'b0;
            wait_valid(lat);
            if (lat == 99) chk($sformatf("pair%0d valid timeout", k), lat, 2);
            chk($sformatf("pair%0d index", k), element_index, k);
            for (int w = 0; w < 5; w++) begin
                if (!delay_valid || element_index != 6'(k) || delay_pos != 12'd7) stable = 1'b0;
                tick();
            end
            delay_ack = 1'b1;
            tick();
            delay_ack = 1'b0;
        end
        term_ready = 1'b0;
        chk("pairs stable while waiting", longint'(stable), 1);
        chk("pairs term_ack count", ack_cnt - a0, 32);
        tick();
        tick();
        chk("pairs done count", done_cnt - d0, 1);
        chk("pairs ack pulse width", ack_long, 0);
        chk("pairs idle after run", longint'(delay_valid), 0);

        // Abort during ADJUST.
        start  = 1'b1;
        d_init = 12'd10;
        tick();
        start      = 1'b0;
        term_pos   = 24'sd2816;
        term_neg   = 24'sd0;
        term_ready = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        a0  = ack_cnt;
        tick();
        chk("abort valid", longint'(delay_valid), 0);
        chk("abort term_ack", longint'(term_ack), 0);
        chk("abort delay_pos", delay_pos, 0);
        chk("abort e_pos", longint'($signed(dut.u_pos.o_e)), 0);
        chk("abort state idle", longint'(dut.r_state), 0);
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("abort no further ack", ack_cnt - a0, 0);
        term_ready = 1'b0;
        run_vector(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
